// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one tagged memory port between the instruction-fetch (IF)
// and data-memory (DM) requesters. DM has fixed priority, and a starvation
// guard hands IF one cycle after it has lost STARVE_MAX cycles in a row.
// A per-tag owner table steers each returning load to the requester that issued it.
module mem_arbiter #(
    parameter int TAG_W      = 4,
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       if_cmd,
    input  logic [31:0]      if_addr,
    output logic [TAG_W-1:0] if_response,
    output logic [31:0]      if_data,
    output logic [TAG_W-1:0] if_tag,
    input  logic [3:0]       dm_cmd,
    input  logic [31:0]      dm_addr,
    input  logic [31:0]      dm_din,
    output logic [TAG_W-1:0] dm_response,
    output logic [31:0]      dm_data,
    output logic [TAG_W-1:0] dm_tag,
    output logic [3:0]       proc2mem_command,
    output logic [31:0]      proc2mem_addr,
    output logic [31:0]      proc2mem_data,
    input  logic [TAG_W-1:0] mem2proc_response,
    input  logic [31:0]      mem2proc_data,
    input  logic [TAG_W-1:0] mem2proc_tag,
    output logic [CNT_W-1:0] if_outstanding,
    output logic [CNT_W-1:0] dm_outstanding,
    output logic             tag_err
);

    // Memory command encodings; any command other than NONE or LW is a store
    // and is forwarded but never recorded in the owner table.
    localparam logic [3:0] MEM_NONE = 4'd0;
    localparam logic [3:0] MEM_LW   = 4'd1;

    localparam int N_TAGS = 1 << TAG_W;
    localparam int SC_W   = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

    // Owner encoding in the table: 0 = IF, 1 = DM.
    logic              if_req;
    logic              dm_req;
    logic              if_wins;
    logic              dm_wins;
    logic [SC_W-1:0]   starve_cnt;
    logic [N_TAGS-1:0] valid_q;
    logic [N_TAGS-1:0] owner_q;
    logic              alloc;
    logic              alloc_owner;
    logic              ret_hit;
    logic              ret_miss;
    logic              ret_owner;
    logic              if_inc;
    logic              if_dec;
    logic              dm_inc;
    logic              dm_dec;

    // Pick the winner: DM by default, IF when DM is idle or IF has starved long enough.
    always_comb begin
        if_req  = (if_cmd != MEM_NONE);
        dm_req  = (dm_cmd != MEM_NONE);
        if_wins = if_req && (!dm_req || (starve_cnt == STARVE_LIM));
        dm_wins = dm_req && !if_wins;
    end

    // Forward the winner's command and hand the memory's accept tag back to it only.
    always_comb begin
        proc2mem_command = MEM_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if_response      = '0;
        dm_response      = '0;
        if (if_wins) begin
            proc2mem_command = if_cmd;
            proc2mem_addr    = if_addr;
            if_response      = mem2proc_response;
        end else if (dm_wins) begin
            proc2mem_command = dm_cmd;
            proc2mem_addr    = dm_addr;
            proc2mem_data    = dm_din;
            dm_response      = mem2proc_response;
        end
        if (!rst) begin
            proc2mem_command = MEM_NONE;
        end
    end

    // Classify this cycle's allocation and return, and steer returning data to its owner.
    always_comb begin
        alloc       = (proc2mem_command == MEM_LW) && (mem2proc_response != '0);
        alloc_owner = dm_wins;
        ret_hit     = rst && (mem2proc_tag != '0) && valid_q[mem2proc_tag];
        ret_miss    = (mem2proc_tag != '0) && !valid_q[mem2proc_tag];
        ret_owner   = owner_q[mem2proc_tag];
        if_tag      = '0;
        dm_tag      = '0;
        if_data     = '0;
        dm_data     = '0;
        if (ret_hit && !ret_owner) begin
            if_tag  = mem2proc_tag;
            if_data = mem2proc_data;
        end
        if (ret_hit && ret_owner) begin
            dm_tag  = mem2proc_tag;
            dm_data = mem2proc_data;
        end
        if_inc = alloc && !alloc_owner;
        dm_inc = alloc && alloc_owner;
        if_dec = ret_hit && !ret_owner;
        dm_dec = ret_hit && ret_owner;
    end

    // Owner table: a return clears its entry first so a same-tag allocation overrides it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            owner_q <= '0;
        end else begin
            if (ret_hit) begin
                valid_q[mem2proc_tag] <= 1'b0;
            end
            if (alloc) begin
                valid_q[mem2proc_response] <= 1'b1;
                owner_q[mem2proc_response] <= alloc_owner;
            end
        end
    end

    // Sticky error flag for any return whose tag has no live owner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_err <= 1'b0;
        end else if (ret_miss) begin
            tag_err <= 1'b1;
        end
    end

    // Count consecutive IF cycles that requested but were not accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (if_req && (if_response == '0)) begin
            if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    // IF loads in flight, saturating at both ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_outstanding <= '0;
        end else if (if_inc && !if_dec && (if_outstanding != '1)) begin
            if_outstanding <= if_outstanding + 1'b1;
        end else if (if_dec && !if_inc && (if_outstanding != '0)) begin
            if_outstanding <= if_outstanding - 1'b1;
        end
    end

    // DM loads in flight, saturating at both ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dm_outstanding <= '0;
        end else if (dm_inc && !dm_dec && (dm_outstanding != '1)) begin
            dm_outstanding <= dm_outstanding + 1'b1;
        end else if (dm_dec && !dm_inc && (dm_outstanding != '0)) begin
            dm_outstanding <= dm_outstanding - 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a scoreboard
// of accepted loads that is drained as the memory returns them.
module tb_mem_arbiter;

    localparam logic [3:0] NONE = 4'd0;
    localparam logic [3:0] LW   = 4'd1;
    localparam logic [3:0] SW   = 4'd2;

    typedef struct packed {
        logic        owner;
        logic [3:0]  tag;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  if_cmd;
    logic [31:0] if_addr;
    logic [3:0]  if_response;
    logic [31:0] if_data;
    logic [3:0]  if_tag;
    logic [3:0]  dm_cmd;
    logic [31:0] dm_addr;
    logic [31:0] dm_din;
    logic [3:0]  dm_response;
    logic [31:0] dm_data;
    logic [3:0]  dm_tag;
    logic [3:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [31:0] proc2mem_data;
    logic [3:0]  mem2proc_response;
    logic [31:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;
    logic [4:0]  if_outstanding;
    logic [4:0]  dm_outstanding;
    logic        tag_err;

    int   n_checks;
    int   n_fail;
    exp_t sb[$];

    mem_arbiter #(.TAG_W(4), .STARVE_MAX(4), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .if_cmd(if_cmd), .if_addr(if_addr), .if_response(if_response),
        .if_data(if_data), .if_tag(if_tag),
        .dm_cmd(dm_cmd), .dm_addr(dm_addr), .dm_din(dm_din),
        .dm_response(dm_response), .dm_data(dm_data), .dm_tag(dm_tag),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data), .mem2proc_response(mem2proc_response),
        .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
        .if_outstanding(if_outstanding), .dm_outstanding(dm_outstanding),
        .tag_err(tag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", name, observed, expected);
        end
    endtask

    // Drive one cycle of inputs just after the falling edge, then settle.
    task automatic applyStimulus(input logic [3:0] ic, input logic [31:0] ia,
                                 input logic [3:0] dc, input logic [31:0] da,
                                 input logic [31:0] dd, input logic [3:0] resp,
                                 input logic [3:0] rtag, input logic [31:0] rdata);
        @(negedge clk);
        if_cmd            = ic;
        if_addr           = ia;
        dm_cmd            = dc;
        dm_addr           = da;
        dm_din            = dd;
        mem2proc_response = resp;
        mem2proc_tag      = rtag;
        mem2proc_data     = rdata;
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(NONE, 32'h0, NONE, 32'h0, 32'h0, 4'd0, 4'd0, 32'h0);
    endtask

    // Pop the oldest expected return, present it from memory and check its routing.
    task automatic returnNext();
        exp_t e;
        e = sb.pop_front();
        applyStimulus(NONE, 32'h0, NONE, 32'h0, 32'h0, 4'd0, e.tag, e.data);
        checkOutput("ret_if_tag",  {28'h0, if_tag},  e.owner ? 32'h0 : {28'h0, e.tag});
        checkOutput("ret_dm_tag",  {28'h0, dm_tag},  e.owner ? {28'h0, e.tag} : 32'h0);
        checkOutput("ret_if_data", if_data, e.owner ? 32'h0 : e.data);
        checkOutput("ret_dm_data", dm_data, e.owner ? e.data : 32'h0);
    endtask

    initial begin
        logic        exp_if;
        logic [3:0]  t;
        n_checks = 0;
        n_fail   = 0;

        // Reset asserted with a pending IF request and a stray return tag.
        rst = 1'b0;
        if_cmd = LW; if_addr = 32'h40; dm_cmd = NONE; dm_addr = 0; dm_din = 0;
        mem2proc_response = 4'd0; mem2proc_tag = 4'd3; mem2proc_data = 32'h1234;
        #2;
        checkOutput("rst_cmd",    {28'h0, proc2mem_command}, {28'h0, NONE});
        checkOutput("rst_if_tag", {28'h0, if_tag}, 32'h0);
        checkOutput("rst_if_out", {27'h0, if_outstanding}, 32'h0);
        checkOutput("rst_dm_out", {27'h0, dm_outstanding}, 32'h0);
        checkOutput("rst_tag_err", {31'h0, tag_err}, 32'h0);
        idleCycle();
        @(negedge clk);
        rst = 1'b1;

        // IF-only load accepted as tag 3, returned later.
        applyStimulus(LW, 32'h40, NONE, 32'h0, 32'h0, 4'd3, 4'd0, 32'h0);
        checkOutput("t2_cmd",  {28'h0, proc2mem_command}, {28'h0, LW});
        checkOutput("t2_addr", proc2mem_addr, 32'h40);
        checkOutput("t2_if_resp", {28'h0, if_response}, 32'h3);
        checkOutput("t2_dm_resp", {28'h0, dm_response}, 32'h0);
        sb.push_back('{owner: 1'b0, tag: 4'd3, data: 32'hDEADBEEF});
        idleCycle();
        checkOutput("t2_if_out1", {27'h0, if_outstanding}, 32'h1);
        returnNext();
        idleCycle();
        checkOutput("t2_if_out0", {27'h0, if_outstanding}, 32'h0);

        // Both request every cycle: DM wins four, IF wins the fifth.
        for (int i = 0; i < 10; i++) begin
            t = 4'(i + 1);
            exp_if = ((i % 5) == 4);
            applyStimulus(LW, 32'h1000 + i, LW, 32'h2000 + i, 32'h0, t, 4'd0, 32'h0);
            checkOutput("t3_addr", proc2mem_addr, exp_if ? 32'h1000 + i : 32'h2000 + i);
            checkOutput("t3_if_resp", {28'h0, if_response}, exp_if ? {28'h0, t} : 32'h0);
            checkOutput("t3_dm_resp", {28'h0, dm_response}, exp_if ? 32'h0 : {28'h0, t});
            sb.push_back('{owner: !exp_if, tag: t, data: 32'hA000_0000 + i});
        end
        idleCycle();
        checkOutput("t3_if_out", {27'h0, if_outstanding}, 32'h2);
        checkOutput("t3_dm_out", {27'h0, dm_outstanding}, 32'h8);
        while (sb.size() > 0) returnNext();
        idleCycle();
        checkOutput("t3_if_out0", {27'h0, if_outstanding}, 32'h0);
        checkOutput("t3_dm_out0", {27'h0, dm_outstanding}, 32'h0);
        checkOutput("t3_tag_err", {31'h0, tag_err}, 32'h0);

        // IF refused by memory four times also counts as starving.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(LW, 32'h300, NONE, 32'h0, 32'h0, 4'd0, 4'd0, 32'h0);
            checkOutput("st_if_resp0", {28'h0, if_response}, 32'h0);
        end
        applyStimulus(LW, 32'h300, LW, 32'h400, 32'h0, 4'd6, 4'd0, 32'h0);
        checkOutput("st_addr", proc2mem_addr, 32'h300);
        checkOutput("st_if_resp", {28'h0, if_response}, 32'h6);
        sb.push_back('{owner: 1'b0, tag: 4'd6, data: 32'h0BAD_F00D});
        returnNext();

        // Same-cycle return of IF tag 5 and DM allocation of tag 5.
        applyStimulus(LW, 32'h50, NONE, 32'h0, 32'h0, 4'd5, 4'd0, 32'h0);
        sb.push_back('{owner: 1'b0, tag: 4'd5, data: 32'h1234_5678});
        applyStimulus(NONE, 32'h0, LW, 32'h60, 32'h0, 4'd5, 4'd5, 32'h1234_5678);
        checkOutput("t5_if_tag",  {28'h0, if_tag}, 32'h5);
        checkOutput("t5_if_data", if_data, 32'h1234_5678);
        checkOutput("t5_dm_tag",  {28'h0, dm_tag}, 32'h0);
        checkOutput("t5_dm_resp", {28'h0, dm_response}, 32'h5);
        void'(sb.pop_front());
        sb.push_back('{owner: 1'b1, tag: 4'd5, data: 32'hCAFE_F00D});
        idleCycle();
        checkOutput("t5_if_out", {27'h0, if_outstanding}, 32'h0);
        checkOutput("t5_dm_out", {27'h0, dm_outstanding}, 32'h1);
        returnNext();

        // DM store: forwarded with data, never recorded; a return of its tag is an error.
        applyStimulus(NONE, 32'h0, SW, 32'h100, 32'h55, 4'd7, 4'd0, 32'h0);
        checkOutput("t4_cmd",  {28'h0, proc2mem_command}, {28'h0, SW});
        checkOutput("t4_data", proc2mem_data, 32'h55);
        checkOutput("t4_dm_resp", {28'h0, dm_response}, 32'h7);
        idleCycle();
        checkOutput("t4_dm_out", {27'h0, dm_outstanding}, 32'h0);
        applyStimulus(NONE, 32'h0, NONE, 32'h0, 32'h0, 4'd0, 4'd7, 32'h77);
        checkOutput("t4_dm_tag", {28'h0, dm_tag}, 32'h0);
        idleCycle();
        checkOutput("t4_tag_err", {31'h0, tag_err}, 32'h1);

        // Reset with two loads in flight; their later returns are dropped.
        applyStimulus(LW, 32'h80, NONE, 32'h0, 32'h0, 4'd8, 4'd0, 32'h0);
        applyStimulus(NONE, 32'h0, LW, 32'h90, 32'h0, 4'd9, 4'd0, 32'h0);
        idleCycle();
        checkOutput("t6_if_out1", {27'h0, if_outstanding}, 32'h1);
        checkOutput("t6_dm_out1", {27'h0, dm_outstanding}, 32'h1);
        applyStimulus(LW, 32'h80, NONE, 32'h0, 32'h0, 4'd0, 4'd8, 32'h88);
        rst = 1'b0;
        sb.delete();
        #1;
        checkOutput("t6_rst_cmd",  {28'h0, proc2mem_command}, {28'h0, NONE});
        checkOutput("t6_rst_tag",  {28'h0, if_tag}, 32'h0);
        checkOutput("t6_rst_ifo",  {27'h0, if_outstanding}, 32'h0);
        checkOutput("t6_rst_dmo",  {27'h0, dm_outstanding}, 32'h0);
        checkOutput("t6_rst_err",  {31'h0, tag_err}, 32'h0);
        idleCycle();
        rst = 1'b1;
        applyStimulus(NONE, 32'h0, NONE, 32'h0, 32'h0, 4'd0, 4'd8, 32'h88);
        checkOutput("t6_if_tag",  {28'h0, if_tag}, 32'h0);
        checkOutput("t6_if_data", if_data, 32'h0);
        applyStimulus(NONE, 32'h0, NONE, 32'h0, 32'h0, 4'd0, 4'd9, 32'h99);
        checkOutput("t6_dm_tag",  {28'h0, dm_tag}, 32'h0);
        checkOutput("t6_dm_data", dm_data, 32'h0);
        for (int i = 0; i < 3; i++) begin
            idleCycle();
            checkOutput("t6_tag_err", {31'h0, tag_err}, 32'h1);
        end
        checkOutput("t6_ifo_end", {27'h0, if_outstanding}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
